// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
//   clk, rst             clock, asynchronous active-high reset
//   start_i              divide present in E (held while stall_o is high)
//   signed_i             1 = DIV, 0 = DIVU
//   annul_i              exception flush, aborts and returns to IDLE
//   opdata1_i/opdata2_i  dividend / divisor
//   stall_o              combinational stall request to the hazard unit
//   ready_o              result valid this cycle (one-cycle pulse)
//   result_o             {remainder, quotient}, held until the next completion
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic               stall_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_d, quo_d, q_fix, r_fix;
    logic             sa_q, sb_q, ready_q;
    logic [2*WIDTH-1:0] result_q;
    logic [WIDTH:0]   trial;
    logic             sa_d, sb_d;
    assign sa_d    = signed_i & opdata1_i[WIDTH-1];
    assign sb_d    = signed_i & opdata2_i[WIDTH-1];
    // Restoring step: shift the next dividend bit into the partial remainder and keep
    // the trial difference only when it did not borrow.
    assign trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    assign quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    assign q_fix   = (sa_q ^ sb_q) ? -quo_d : quo_d;
    assign r_fix   = sa_q ? -rem_d : rem_d;
    assign stall_o = ~annul_i & ((state_q == S_IDLE & start_i) | state_q == S_ON | state_q == S_DIVZERO);
    assign ready_o = ready_q;
    assign result_o = result_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else if (annul_i) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    sa_q    <= sa_d;
                    sb_q    <= sb_d;
                    dvs_q   <= sb_d ? -opdata2_i : opdata2_i;
                    rem_q   <= '0;
                    // A zero divisor keeps the raw dividend here for the forced remainder.
                    quo_q   <= (opdata2_i == '0) ? opdata1_i : (sa_d ? -opdata1_i : opdata1_i);
                    cnt_q   <= '0;
                    state_q <= (opdata2_i == '0) ? S_DIVZERO : S_ON;
                end
                S_ON: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q  <= S_END;
                        ready_q  <= 1'b1;
                        result_q <= {r_fix, q_fix};
                    end
                end
                S_DIVZERO: begin
                    state_q  <= S_END;
                    ready_q  <= 1'b1;
                    result_q <= {quo_q, {WIDTH{1'b1}}};
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic model.
module tb_div_unit;
    logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, signed_i = 1'b0, annul_i = 1'b0;
    logic [31:0] opdata1_i = '0, opdata2_i = '0;
    logic        stall_o, ready_o;
    logic [63:0] result_o;
    int          n_chk = 0, n_pass = 0, cyc_abs = 0, last_rdy = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .stall_o(stall_o), .ready_o(ready_o), .result_o(result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = s ? longint'(signed'(a)) : longint'(a);
        sb = s ? longint'(signed'(b)) : longint'(b);
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Entered and left at posedge+1; start stays high through the ready cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int lat = (b == 32'd0) ? 2 : 33;
        int nst = 0;
        bit got = 0;
        start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (stall_o) nst++;
            if (ready_o) begin
                got = 1;
                last_rdy = cyc_abs;
                chk("latency", 64'(c), 64'(lat));
                chk("result", result_o, ref_div(a, b, s));
                chk("stall_in_end", 64'(stall_o), 64'd0);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("ready_seen", 64'(got), 64'd1);
        chk("stall_cycles", 64'(nst), 64'(lat));
        @(posedge clk); #1;
        chk("ready_one_cycle", 64'(ready_o), 64'd0);
    endtask

    task automatic quiet(input int n, input string tag);
        int nr = 0, ns = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            if (ready_o) nr++;
            if (stall_o) ns++;
        end
        chk({tag, "_no_ready"}, 64'(nr), 64'd0);
        chk({tag, "_no_stall"}, 64'(ns), 64'd0);
    endtask

    initial begin
        logic [63:0] prev;
        #12;
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        do_op(32'd100, 32'd7, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1);
        do_op(32'h1234_5678, 32'd0, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd0, 1'b1);

        do_op(32'd50, 32'd5, 1'b0);
        prev = 64'(last_rdy);
        do_op(32'd9, 32'd4, 1'b0);
        chk("b2b_spacing", 64'(last_rdy) - prev, 64'd34);

        // Annul in cycle 10 of an operation.
        prev = result_o;
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        annul_i = 1'b1;
        #1 chk("annul_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        #1 chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_result_kept", result_o, prev);
        quiet(40, "annul");
        @(posedge clk); #1;
        do_op(32'd1000, 32'd3, 1'b0);

        // Annul beats start in IDLE.
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd2;
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        quiet(40, "annul_idle");

        // Asynchronous reset mid-operation.
        @(posedge clk); #1;
        start_i = 1'b1; opdata1_i = 32'd77; opdata2_i = 32'd3;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1 chk("arst_ready", 64'(ready_o), 64'd0);
        chk("arst_result", result_o, 64'd0);
        start_i = 1'b0;
        #1 chk("arst_stall", 64'(stall_o), 64'd0);
        #1 rst = 1'b0;
        quiet(40, "arst");

        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            do_op(a, b, 1'($urandom_range(0, 1)));
        end
        start_i = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
